// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: hazard stalls, branch flushes and memory-wait
// handling. Define PIPE_STALL_CNT_EN to build the saturating stall-cycle counter.
module pipe_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wrreg,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic [1:0]       state,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // state    | meaning
  // RUN      | normal flow; hazards and branches handled combinationally
  // MEM_WAIT | data memory busy; everything up to EX/MEM frozen
  // ERR      | memory timed out; pipeline frozen until rst
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_V = 8'(MEM_TIMEOUT);

  state_t     cur;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic       err_q;
  logic       load_use;
  logic       mem_stall;

  assign wait_nxt  = wait_cnt + 8'd1;
  assign load_use  = ex_memread && (ex_wrreg != 5'd0) &&
                     ((ex_wrreg == id_rs) || (id_uses_rt && (ex_wrreg == id_rt)));
  assign mem_stall = ((cur == RUN) && mem_req && !mem_ack) ||
                     ((cur == MEM_WAIT) && !mem_ack);

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (cur == ERR) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (branch_taken) begin
      // a taken branch discards the hazarding instruction, so no PC stall
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= RUN;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      case (cur)
        RUN: begin
          if (mem_req && !mem_ack) cur <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            cur      <= RUN;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == TIMEOUT_V) begin
              cur   <= ERR;
              err_q <= 1'b1;
            end
          end
        end
        default: cur <= ERR;
      endcase
    end
  end

  assign state           = cur;
  assign mem_timeout_err = err_q;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pc_en && (cur != ERR) && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl (MEM_TIMEOUT=4): expected control vectors
// are queued as each cycle is driven and popped when the outputs settle.
module tb_pipe_seq_ctrl;
  localparam int CNT_W = 16;

  // {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb flushes}
  localparam logic [8:0] C_DEF = 9'b11111_0000;
  localparam logic [8:0] C_LU  = 9'b00111_0100;
  localparam logic [8:0] C_BR  = 9'b11111_1100;
  localparam logic [8:0] C_MEM = 9'b00001_0001;
  localparam logic [8:0] C_ERR = 9'b00000_0000;
  localparam logic [8:0] C_RST = 9'b00000_1111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_wrreg = '0;
  logic id_uses_rt = 1'b0, ex_memread = 1'b0, branch_taken = 1'b0;
  logic mem_req = 1'b0, mem_ack = 1'b0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [1:0] state;
  logic mem_timeout_err;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct packed {
    logic [8:0]       ctl;
    logic [1:0]       st;
    logic             err;
    logic [CNT_W-1:0] sc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_stall = '0;

  always #5 clk = ~clk;

  pipe_seq_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_wrreg(ex_wrreg),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .state(state), .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt)
  );

  function automatic logic [8:0] ctl_now();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, memwb_flush};
  endfunction

  // One cycle: drive after the falling edge, check 2 ns later, well before the rising edge.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic mr, input logic [4:0] wr, input logic br,
                      input logic req, input logic ack,
                      input logic [8:0] ectl, input logic [1:0] est, input string name);
    exp_t e;
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mr; ex_wrreg = wr;
    branch_taken = br; mem_req = req; mem_ack = ack;
    q.push_back('{ctl: ectl, st: est, err: (est == 2'd2), sc: exp_stall});
`ifdef PIPE_STALL_CNT_EN
    if (!ectl[8] && est != 2'd2) exp_stall = exp_stall + 1'b1;
`endif
    #2;
    e = q.pop_front();
    checks++;
    if (ctl_now() !== e.ctl) begin
      errors++;
      $display("FAIL %s ctl got %b expected %b", name, ctl_now(), e.ctl);
    end
    checks++;
    if (state !== e.st) begin
      errors++;
      $display("FAIL %s state got %0d expected %0d", name, state, e.st);
    end
    checks++;
    if (mem_timeout_err !== e.err) begin
      errors++;
      $display("FAIL %s mem_timeout_err got %b expected %b", name, mem_timeout_err, e.err);
    end
    checks++;
    if (stall_cnt !== e.sc) begin
      errors++;
      $display("FAIL %s stall_cnt got %0d expected %0d", name, stall_cnt, e.sc);
    end
  endtask

  task automatic idle(input string name);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_DEF, 2'd0, name);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_memread = 1'b0; ex_wrreg = '0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_stall = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (ctl_now() !== C_RST) begin
      errors++;
      $display("FAIL reset_ctl got %b expected %b", ctl_now(), C_RST);
    end
    checks++;
    if (state !== 2'd0 || mem_timeout_err !== 1'b0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_regs got st=%0d err=%b sc=%0d expected 0 0 0",
               state, mem_timeout_err, stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_stall = '0;
    idle("reset_release");
  endtask

  task automatic test_load_use();
    step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU,  2'd0, "lu_rs");
    idle("lu_after");
    step(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_LU,  2'd0, "lu_rt");
    step(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_DEF, 2'd0, "lu_rt_unused");
    step(5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_DEF, 2'd0, "lu_not_load");
    idle("lu_end");
  endtask

  task automatic test_branch_hazard();
    step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_BR, 2'd0, "br_hazard");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_BR, 2'd0, "br_only");
    idle("br_end");
  endtask

  task automatic test_wrreg_zero();
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_DEF, 2'd0, "wrreg_zero");
    idle("wrreg_zero_end");
  endtask

  task automatic test_mem_wait();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_DEF, 2'd0, "mem_zero_wait");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_DEF, 2'd0, "ack_no_req");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, C_MEM, 2'd0, "mem_w0_br");
    step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, C_MEM, 2'd1, "mem_w1_lu");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM, 2'd1, "mem_w2");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_DEF, 2'd1, "mem_ack");
    idle("mem_back_run");
  endtask

  task automatic test_reset_mid_wait();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM, 2'd0, "rmw_w0");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM, 2'd1, "rmw_w1");
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ctl_now() !== C_RST || state !== 2'd0) begin
      errors++;
      $display("FAIL rmw_async got ctl=%b st=%0d expected ctl=%b st=0",
               ctl_now(), state, C_RST);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_req = 1'b0;
    exp_stall = '0;
    idle("rmw_release");
  endtask

  task automatic test_timeout();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM, 2'd0, "to_e0");
    for (int i = 1; i <= 4; i++)
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM, 2'd1, $sformatf("to_w%0d", i));
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_ERR, 2'd2, "to_err");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_ERR, 2'd2, "to_err_ack");
    step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_ERR, 2'd2, "to_err_hold");
    apply_reset();
    idle("to_recovered");
  endtask

  task automatic test_back_to_back();
    step(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, C_LU,  2'd0, "b2b_lu");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_BR,  2'd0, "b2b_br");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM, 2'd0, "b2b_mem");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_DEF, 2'd1, "b2b_ack");
    idle("b2b_end");
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_hazard();
    test_wrreg_zero();
    test_mem_wait();
    test_reset_mid_wait();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of MEM_WAIT cycles tolerated before the block enters ERR (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports id_rs and id_rt, input, 5 bits each: source registers of the instruction in ID.
REQ-006 SHALL have port id_uses_rt, input, 1 bit: the ID instruction reads rt.
REQ-007 SHALL have port ex_memread, input, 1 bit, and port ex_wrreg, input, 5 bits: the instruction in EX is a load, and its destination register.
REQ-008 SHALL have port branch_taken, input, 1 bit: a branch resolved taken in EX.
REQ-009 SHALL have ports mem_req and mem_ack, input, 1 bit each: the MEM stage holds a data-memory access, and the memory completes it this cycle.
REQ-010 SHALL have ports pc_en, ifid_en, idex_en, exmem_en and memwb_en, output, 1 bit each: load enables for the PC and the four pipeline registers.
REQ-011 SHALL have ports ifid_flush, idex_flush, exmem_flush and memwb_flush, output, 1 bit each: synchronous bubble insert, where WB=0 and WrReg=0.
REQ-012 SHALL have port state, output, 2 bits: RUN=0, MEM_WAIT=1, ERR=2.
REQ-013 SHALL have port mem_timeout_err, output, 1 bit: sticky error flag.
REQ-014 SHALL have port stall_cnt, output, CNT_W bits: count of stall cycles.

Function
REQ-015 SHALL drive enables and flushes combinationally (Mealy) from state and inputs, so a stall takes effect in the same cycle it is detected.
REQ-016 SHALL, in the default case, set all enables to 1 and all flushes to 0.
REQ-017 SHALL detect load-use when ex_memread=1, ex_wrreg!=0, and ex_wrreg equals id_rs, or equals id_rt with id_uses_rt=1.
REQ-018 SHALL respond to load-use with pc_en=0, ifid_en=0 and idex_flush=1 for exactly one cycle.
REQ-019 SHALL respond to branch_taken with ifid_flush=1 and idex_flush=1, with pc_en=1.
REQ-020 SHALL, in RUN with mem_req=1 and mem_ack=0, set pc_en, ifid_en, idex_en and exmem_en to 0, set memwb_flush=1, and go to MEM_WAIT on the next edge.
REQ-021 SHALL treat mem_req=1 with mem_ack=1 in RUN as a zero-wait access: no stall.
REQ-022 SHALL, in MEM_WAIT with mem_ack=0, hold the same stall outputs as REQ-020 and increment an 8-bit wait counter.
REQ-023 SHALL, in MEM_WAIT, go to ERR on the edge where the wait counter reaches MEM_TIMEOUT.
REQ-024 SHALL, in MEM_WAIT with mem_ack=1, output the default case, go to RUN on the next edge and clear the wait counter.
REQ-025 SHALL, in ERR, hold all enables at 0 and all flushes at 0, with mem_timeout_err=1, until rst.
REQ-026 SHALL apply priority: memory stall first, then branch_taken, then load-use; lower-priority events are ignored that cycle and re-evaluated later (EX is frozen, so its inputs persist).
REQ-027 SHALL, when branch_taken and load-use coincide, flush only, with no PC stall.
REQ-028 SHALL treat mem_ack in RUN without mem_req as a don't-care.
REQ-029 SHALL treat ex_wrreg=0 as never hazardous.

Reset
REQ-030 SHALL, while rst=1, hold state=RUN, wait counter=0, mem_timeout_err=0 and stall_cnt=0.
REQ-031 SHALL, while rst=1, drive all enables to 0 and all flushes to 1.
REQ-032 SHALL, on rst asserted mid-MEM_WAIT or in ERR, abandon the stall immediately and leave the block in RUN after release.
REQ-033 SHALL behave normally from the first rising clk edge after rst deasserts.

Configuration
REQ-034 SHALL, with PIPE_STALL_CNT_EN defined, increment stall_cnt on every cycle with pc_en=0 and state!=ERR, saturating at all-ones.
REQ-035 SHALL, without PIPE_STALL_CNT_EN, tie stall_cnt to 0 and implement no counter logic; all other behaviour is identical.

Verification
REQ-036 SHALL cover load-use: ex_memread=1, ex_wrreg=5, id_rs=5 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle, then defaults; stall_cnt=1 with the macro.
REQ-037 SHALL cover branch plus hazard: branch_taken=1 with the REQ-036 hazard -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-038 SHALL cover a memory wait: mem_req=1, mem_ack low for 3 cycles then high -> state 0,1,1,1 then 0; memwb_flush=1 for 3 cycles; stall_cnt=3.
REQ-039 SHALL cover timeout: MEM_TIMEOUT=4, mem_ack held 0 -> state=2 and mem_timeout_err=1 after 5 edges; enables stay 0 with ack later high.
REQ-040 SHALL cover reset in MEM_WAIT: assert rst mid-MEM_WAIT -> state=0, all flushes 1 immediately without clock; defaults resume after release.
REQ-041 SHALL cover ex_wrreg=0: ex_memread=1, ex_wrreg=0, id_rs=0 -> no stall.
